udp_128bit_recv: RTL and testbench

- Receive-side counterpart of the 128-bit UDP sender in the CAM2PC path.
- Consumes the UDP RX payload byte stream and strips the 2-byte segment header {last_frame_flag, mjpeg_frame_rank[14:0]}.
- Packs the remaining JPEG bytes MSB-first into 128-bit words and hands them to the DDR3 write side with a valid/ready handshake.
- Contains one assembly register plus one output holding register, so the byte stream never stalls while a word waits for DDR3.

---
 rtl/udp_128bit_recv.sv | 222 ++++++++++++++++++++++
 tb/tb_udp_128bit_recv.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_128bit_recv.sv
// Purpose: strips the 2-byte segment header from the UDP RX byte stream and packs JPEG bytes MSB-first into 128-bit DDR3 words.
// Latency: final byte of a word -> o_ddr3_wr_valid one clock later; header fields one clock after the second header byte.
// Backpressure: one holding register absorbs DDR3 stalls; a word completing while it is still full is dropped and flagged as overflow.
module udp_128bit_recv #(
    parameter int LEN_W   = 16,
    parameter int MIN_LEN = 3
) (
    input  logic             i_udp_clk50m,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_udp_rx_sof,
    input  logic [LEN_W-1:0] i_udp_rx_len,
    input  logic             i_udp_rx_de,
    input  logic [7:0]       i_udp_rx_data,
    input  logic             i_udp_rx_err,
    output logic [127:0]     o_ddr3_wrdata,
    output logic             o_ddr3_wr_valid,
    input  logic             i_ddr3_wr_ready,
    output logic             o_ddr3_wr_last,
    output logic             o_last_frame_flag,
    output logic [14:0]      o_mjpeg_frame_rank,
    output logic [LEN_W-1:0] o_udp_jpeg_len,
    output logic             o_hdr_valid,
    output logic             o_pkt_done,
    output logic             o_pkt_err,
    output logic             o_overflow,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_HI    = 3'd1,
        HDR_LO    = 3'd2,
        PAYLOAD   = 3'd3,
        FLUSH     = 3'd4,
        WAIT_LAST = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rx_len_q;
    logic [LEN_W-1:0] bcnt_q;
    logic [LEN_W-1:0] bcnt_inc;
    logic [3:0]       lane_q;
    logic [127:0]     asm_q;
    logic [127:0]     asm_ins;

    logic start, len_err, cap_hi, cap_lo, pay_byte, word_load, ovf_ev, abort, done_ev;
    logic hold_fire, is_final, word_done;

    assign bcnt_inc  = bcnt_q + LEN_W'(1);
    assign is_final  = (bcnt_inc == o_udp_jpeg_len);
    assign word_done = (lane_q == 4'hF) || is_final;
    assign hold_fire = o_ddr3_wr_valid && i_ddr3_wr_ready;
    assign o_busy    = (state_q != IDLE);

    // Assembly register with the incoming byte placed in lane (15 - lane), i.e. byte 0 at [127:120].
    always_comb begin
        asm_ins = asm_q;
        asm_ins[{~lane_q, 3'b000} +: 8] = i_udp_rx_data;
    end

    // State register.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes; a stray sof mid-packet is treated exactly like an error.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        len_err   = 1'b0;
        cap_hi    = 1'b0;
        cap_lo    = 1'b0;
        pay_byte  = 1'b0;
        word_load = 1'b0;
        ovf_ev    = 1'b0;
        abort     = 1'b0;
        done_ev   = 1'b0;
        if (state_q == IDLE) begin
            if (i_en && i_udp_rx_sof) begin
                if (i_udp_rx_len < MIN_LEN_V) begin
                    len_err = 1'b1;
                end else begin
                    start   = 1'b1;
                    state_d = HDR_HI;
                end
            end
        end else if (i_udp_rx_err || i_udp_rx_sof) begin
            abort   = 1'b1;
            state_d = FLUSH;
        end else begin
            case (state_q)
                HDR_HI: begin
                    if (i_udp_rx_de) begin
                        cap_hi  = 1'b1;
                        state_d = HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (i_udp_rx_de) begin
                        cap_lo  = 1'b1;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (i_udp_rx_de) begin
                        pay_byte = 1'b1;
                        if (word_done) begin
                            if (o_ddr3_wr_valid && !i_ddr3_wr_ready) begin
                                ovf_ev  = 1'b1;
                                state_d = FLUSH;
                            end else begin
                                word_load = 1'b1;
                                if (is_final) begin
                                    state_d = WAIT_LAST;
                                end
                            end
                        end
                    end
                end
                WAIT_LAST: begin
                    if (hold_fire) begin
                        done_ev = 1'b1;
                        state_d = IDLE;
                    end
                end
                FLUSH: begin
                    if (!o_ddr3_wr_valid) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Packet bookkeeping: length latch, byte and lane counters, header fields.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_len_q           <= '0;
            bcnt_q             <= '0;
            lane_q             <= '0;
            o_last_frame_flag  <= 1'b0;
            o_mjpeg_frame_rank <= '0;
            o_udp_jpeg_len     <= '0;
        end else begin
            if (start) begin
                rx_len_q <= i_udp_rx_len;
                bcnt_q   <= '0;
                lane_q   <= '0;
            end else if (pay_byte) begin
                bcnt_q <= bcnt_inc;
                lane_q <= lane_q + 4'd1;
            end
            if (cap_hi) begin
                o_last_frame_flag        <= i_udp_rx_data[7];
                o_mjpeg_frame_rank[14:8] <= i_udp_rx_data[6:0];
            end
            if (cap_lo) begin
                o_mjpeg_frame_rank[7:0] <= i_udp_rx_data;
                o_udp_jpeg_len          <= rx_len_q - LEN_W'(2);
            end
        end
    end

    // Assembly register: cleared on packet start, on every word hand-off and whenever the packet is discarded.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            asm_q <= '0;
        end else if (start || abort || ovf_ev || word_load) begin
            asm_q <= '0;
        end else if (pay_byte) begin
            asm_q <= asm_ins;
        end
    end

    // Holding register toward DDR3; reloads in the same cycle it is accepted, so there is no bubble.
    // When the packet is dropped with a word still pending, that word is marked last so the burst closes.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ddr3_wrdata   <= '0;
            o_ddr3_wr_valid <= 1'b0;
            o_ddr3_wr_last  <= 1'b0;
        end else begin
            if (word_load) begin
                o_ddr3_wrdata   <= asm_ins;
                o_ddr3_wr_valid <= 1'b1;
                o_ddr3_wr_last  <= is_final;
            end else if (hold_fire) begin
                o_ddr3_wr_valid <= 1'b0;
                o_ddr3_wr_last  <= 1'b0;
            end
            if ((abort || ovf_ev) && o_ddr3_wr_valid && !hold_fire) begin
                o_ddr3_wr_last <= 1'b1;
            end
        end
    end

    // Status pulses and the sticky overflow flag.
    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hdr_valid <= 1'b0;
            o_pkt_done  <= 1'b0;
            o_pkt_err   <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_hdr_valid <= cap_lo;
            o_pkt_done  <= done_ev;
            o_pkt_err   <= len_err || abort || ovf_ev;
            if (ovf_ev) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_udp_128bit_recv.sv
// Bench for udp_128bit_recv: randomized packets against a queue-based reference model.
// Stimulus pushes expected words/headers; an independent monitor pops them on each handshake.
// Ready is driven by a separate process in one of several patterns.
module tb_udp_128bit_recv;

    logic         i_udp_clk50m;
    logic         i_rst_n;
    logic         i_en;
    logic         i_udp_rx_sof;
    logic [15:0]  i_udp_rx_len;
    logic         i_udp_rx_de;
    logic [7:0]   i_udp_rx_data;
    logic         i_udp_rx_err;
    logic [127:0] o_ddr3_wrdata;
    logic         o_ddr3_wr_valid;
    logic         i_ddr3_wr_ready;
    logic         o_ddr3_wr_last;
    logic         o_last_frame_flag;
    logic [14:0]  o_mjpeg_frame_rank;
    logic [15:0]  o_udp_jpeg_len;
    logic         o_hdr_valid;
    logic         o_pkt_done;
    logic         o_pkt_err;
    logic         o_overflow;
    logic         o_busy;

    udp_128bit_recv #(.LEN_W(16), .MIN_LEN(3)) dut (
        .i_udp_clk50m      (i_udp_clk50m),
        .i_rst_n           (i_rst_n),
        .i_en              (i_en),
        .i_udp_rx_sof      (i_udp_rx_sof),
        .i_udp_rx_len      (i_udp_rx_len),
        .i_udp_rx_de       (i_udp_rx_de),
        .i_udp_rx_data     (i_udp_rx_data),
        .i_udp_rx_err      (i_udp_rx_err),
        .o_ddr3_wrdata     (o_ddr3_wrdata),
        .o_ddr3_wr_valid   (o_ddr3_wr_valid),
        .i_ddr3_wr_ready   (i_ddr3_wr_ready),
        .o_ddr3_wr_last    (o_ddr3_wr_last),
        .o_last_frame_flag (o_last_frame_flag),
        .o_mjpeg_frame_rank(o_mjpeg_frame_rank),
        .o_udp_jpeg_len    (o_udp_jpeg_len),
        .o_hdr_valid       (o_hdr_valid),
        .o_pkt_done        (o_pkt_done),
        .o_pkt_err         (o_pkt_err),
        .o_overflow        (o_overflow),
        .o_busy            (o_busy)
    );

    typedef struct packed {
        logic [127:0] d;
        logic         last;
        logic         chk_last;
    } exp_word_t;

    typedef struct packed {
        logic        flag;
        logic [14:0] rank;
        logic [15:0] jlen;
    } exp_hdr_t;

    exp_word_t  exp_q[$];
    exp_hdr_t   hdr_q[$];
    logic [7:0] pl[$];
    logic [15:0] hdr;

    int total = 0;
    int bad = 0;
    int exp_done = 0;
    int got_done = 0;
    int exp_err = 0;
    int got_err = 0;
    int rdy_mode = 0;
    int hold_n = 0;
    int rdy_gen = 0;

    initial begin
        i_udp_clk50m = 1'b0;
        forever #5 i_udp_clk50m = ~i_udp_clk50m;
    end

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge i_udp_clk50m);
        #1;
    endtask

    // Reference model: payload split into 16-byte chunks, first byte in the top byte, short tail zero-padded.
    function automatic logic [127:0] word_of(input int w);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (w * 16 + k < pl.size()) r[127 - 8 * k -: 8] = pl[w * 16 + k];
        end
        return r;
    endfunction

    task automatic gen_payload(input int len, input bit seq);
        pl.delete();
        for (int i = 0; i < len - 2; i++) pl.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    task automatic push_hdr();
        exp_hdr_t h;
        h.flag = hdr[15];
        h.rank = hdr[14:0];
        h.jlen = 16'(pl.size());
        hdr_q.push_back(h);
    endtask

    task automatic push_word(input int w, input logic last, input logic chk);
        exp_word_t e;
        e.d = word_of(w);
        e.last = last;
        e.chk_last = chk;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt();
        int nw;
        nw = (pl.size() + 15) / 16;
        push_hdr();
        for (int w = 0; w < nw; w++) push_word(w, (w == nw - 1), 1'b1);
        exp_done++;
    endtask

    task automatic set_ready(input int mode, input int n);
        rdy_mode = mode;
        hold_n = n;
        rdy_gen++;
    endtask

    // abort_kind: 0 none, 1 rx_err, 2 stray sof, 3 async reset; applied before payload byte abort_at.
    task automatic send(input int gapmax, input int abort_kind, input int abort_at, input int surplus);
        i_udp_rx_sof = 1'b1;
        i_udp_rx_len = 16'(pl.size() + 2);
        tick();
        i_udp_rx_sof = 1'b0;
        for (int b = 0; b < 2; b++) begin
            repeat ($urandom_range(0, gapmax)) tick();
            i_udp_rx_de = 1'b1;
            i_udp_rx_data = (b == 0) ? hdr[15:8] : hdr[7:0];
            tick();
            i_udp_rx_de = 1'b0;
        end
        for (int i = 0; i < pl.size() + surplus; i++) begin
            if (abort_kind != 0 && i == abort_at) begin
                if (abort_kind == 1) begin
                    i_udp_rx_err = 1'b1;
                    tick();
                    i_udp_rx_err = 1'b0;
                end else if (abort_kind == 2) begin
                    i_udp_rx_sof = 1'b1;
                    i_udp_rx_len = 16'd40;
                    tick();
                    i_udp_rx_sof = 1'b0;
                end else begin
                    #2 i_rst_n = 1'b0;
                    #1;
                    check("rst_mid_valid", 128'(o_ddr3_wr_valid), 128'(0));
                    check("rst_mid_busy", 128'(o_busy), 128'(0));
                    @(negedge i_udp_clk50m);
                    i_rst_n = 1'b1;
                    tick();
                end
                return;
            end
            repeat ($urandom_range(0, gapmax)) tick();
            i_udp_rx_de = 1'b1;
            i_udp_rx_data = (i < pl.size()) ? pl[i] : 8'($urandom);
            tick();
            i_udp_rx_de = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 400) begin
            tick();
            n++;
        end
        check(name, 128'(o_busy), 128'(0));
    endtask

    // Ready driver.
    initial begin
        int seen_gen;
        int cnt;
        bit started;
        seen_gen = 0;
        cnt = 0;
        started = 1'b0;
        i_ddr3_wr_ready = 1'b0;
        forever begin
            tick();
            if (rdy_gen != seen_gen) begin
                seen_gen = rdy_gen;
                cnt = 0;
                started = 1'b0;
            end
            case (rdy_mode)
                0: i_ddr3_wr_ready = 1'b1;
                1: i_ddr3_wr_ready = ~i_ddr3_wr_ready;
                2: i_ddr3_wr_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (started) cnt++;
                    if (o_ddr3_wr_valid) started = 1'b1;
                    i_ddr3_wr_ready = started && (cnt >= hold_n);
                end
            endcase
        end
    end

    // Monitor: pops expectations on each accepted word / header pulse, checks held data stays stable.
    initial begin
        logic         stalled;
        logic [127:0] prev_d;
        exp_word_t    e;
        exp_hdr_t     h;
        stalled = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge i_udp_clk50m);
            if (i_rst_n) begin
                if (o_ddr3_wr_valid && stalled) check("hold_stable", o_ddr3_wrdata, prev_d);
                if (o_ddr3_wr_valid && i_ddr3_wr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", o_ddr3_wrdata, 128'(0));
                        total++;
                        bad++;
                        $display("FAIL word_extra: got a word, want none");
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", o_ddr3_wrdata, e.d);
                        if (e.chk_last) check("word_last", 128'(o_ddr3_wr_last), 128'(e.last));
                    end
                end
                if (o_hdr_valid) begin
                    if (hdr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL hdr_extra: got hdr_valid, want none");
                    end else begin
                        h = hdr_q.pop_front();
                        check("hdr_flag", 128'(o_last_frame_flag), 128'(h.flag));
                        check("hdr_rank", 128'(o_mjpeg_frame_rank), 128'(h.rank));
                        check("hdr_jlen", 128'(o_udp_jpeg_len), 128'(h.jlen));
                    end
                end
                if (o_pkt_done) got_done++;
                if (o_pkt_err) got_err++;
            end
            stalled = o_ddr3_wr_valid && !i_ddr3_wr_ready;
            prev_d = o_ddr3_wrdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_en = 1'b1;
        i_udp_rx_sof = 1'b0;
        i_udp_rx_len = '0;
        i_udp_rx_de = 1'b0;
        i_udp_rx_data = '0;
        i_udp_rx_err = 1'b0;
        repeat (3) tick();
        check("rst_valid", 128'(o_ddr3_wr_valid), 128'(0));
        check("rst_data", o_ddr3_wrdata, 128'(0));
        check("rst_last", 128'(o_ddr3_wr_last), 128'(0));
        check("rst_busy", 128'(o_busy), 128'(0));
        check("rst_ovf", 128'(o_overflow), 128'(0));
        check("rst_err", 128'(o_pkt_err), 128'(0));
        check("rst_jlen", 128'(o_udp_jpeg_len), 128'(0));
        @(negedge i_udp_clk50m);
        i_rst_n = 1'b1;
        tick();

        // Two full words, flag=1 rank=5.
        set_ready(0, 0);
        hdr = 16'h8005;
        gen_payload(34, 1'b1);
        exp_pkt();
        send(0, 0, 0, 0);
        wait_idle("idle_t1");

        // Partial second word, zero padded.
        gen_payload(21, 1'b1);
        hdr = 16'h0123;
        exp_pkt();
        send(0, 0, 0, 0);
        wait_idle("idle_t2");

        // Overflow: DDR3 stalls 40 cycles after the first word.
        check("ovf_before", 128'(o_overflow), 128'(0));
        set_ready(3, 40);
        hdr = 16'h1234;
        gen_payload(50, 1'b1);
        push_hdr();
        push_word(0, 1'b1, 1'b0);
        exp_err++;
        send(0, 0, 0, 0);
        wait_idle("idle_ovf");
        check("ovf_after", 128'(o_overflow), 128'(1));

        // rx_err after 7 payload bytes, then a clean packet.
        set_ready(0, 0);
        hdr = 16'h7FFF;
        gen_payload(40, 1'b0);
        push_hdr();
        exp_err++;
        send(0, 1, 7, 0);
        wait_idle("idle_err");
        hdr = 16'h4321;
        gen_payload(30, 1'b0);
        exp_pkt();
        send(1, 0, 0, 0);
        wait_idle("idle_after_err");

        // Too short, then minimum length; disabled block ignores sof.
        i_udp_rx_sof = 1'b1;
        i_udp_rx_len = 16'd2;
        tick();
        i_udp_rx_sof = 1'b0;
        exp_err++;
        check("short_busy", 128'(o_busy), 128'(0));
        i_en = 1'b0;
        i_udp_rx_sof = 1'b1;
        i_udp_rx_len = 16'd20;
        tick();
        i_udp_rx_sof = 1'b0;
        i_en = 1'b1;
        check("dis_busy", 128'(o_busy), 128'(0));
        hdr = 16'h8001;
        gen_payload(3, 1'b0);
        pl[0] = 8'hAB;
        exp_pkt();
        send(0, 0, 0, 0);
        wait_idle("idle_min");

        // Asynchronous reset mid-packet clears overflow and emits nothing.
        hdr = 16'h0AAA;
        gen_payload(40, 1'b0);
        push_hdr();
        send(0, 3, 10, 0);
        check("rst_ovf_clear", 128'(o_overflow), 128'(0));

        // Ready toggling every cycle, 64 bytes back-to-back.
        set_ready(1, 0);
        hdr = 16'h0042;
        gen_payload(66, 1'b0);
        exp_pkt();
        send(0, 0, 0, 0);
        wait_idle("idle_toggle");
        check("toggle_ovf", 128'(o_overflow), 128'(0));

        // Stray sof while a word is pending: word completes with last forced.
        set_ready(3, 5);
        hdr = 16'h5555;
        gen_payload(60, 1'b0);
        push_hdr();
        push_word(0, 1'b1, 1'b1);
        exp_err++;
        send(0, 2, 17, 0);
        wait_idle("idle_sof");

        // Random packets with gaps, surplus bytes and random ready.
        set_ready(2, 0);
        for (int p = 0; p < 10; p++) begin
            hdr = 16'($urandom);
            gen_payload($urandom_range(3, 80), 1'b0);
            exp_pkt();
            send(2, 0, 0, $urandom_range(0, 3));
            wait_idle("idle_rand");
        end

        repeat (20) tick();
        check("words_left", 128'(exp_q.size()), 128'(0));
        check("hdrs_left", 128'(hdr_q.size()), 128'(0));
        check("done_count", 128'(got_done), 128'(exp_done));
        check("err_count", 128'(got_err), 128'(exp_err));
        check("final_ovf", 128'(o_overflow), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
